// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch and field-decode stage for the 8-bit
// accumulator processor. It owns the fetch PC and addresses an external
// instruction memory with a combinational read. It latches the fetched word
// into IR and slices IR into ALU control fields. A taken branch redirects
// fetch and squashes the single wrong-path fetch.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, startAddr  begin execution at startAddr (honoured in IDLE/HALT)
//   stall             freeze the whole stage
//   branch, target    ALU redirect for the instruction currently in IR
//   imemAddr/imemData instruction memory address / same-cycle read data
//   typeCode,rOp,regSel,iOp,imm  decode slices of IR
//   instrValid        IR holds an instruction to execute this cycle
//   pc                address of the instruction in IR
//   done              HALT retired (sticky until start/reset)
//   instrCount        saturating retired-instruction count
module fetch_decode #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    startAddr,
  input  logic               stall,
  input  logic               branch,
  input  logic [PC_W-1:0]    target,
  output logic [PC_W-1:0]    imemAddr,
  input  logic [INSTR_W-1:0] imemData,
  output logic               typeCode,
  output logic [3:0]         rOp,
  output logic [3:0]         regSel,
  output logic [2:0]         iOp,
  output logic [4:0]         imm,
  output logic               instrValid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [CNT_W-1:0]   instrCount
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t             state_q, state_d;
  logic [PC_W-1:0]    fetch_q, fetch_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_halt;

  // HALT reuses the unused I-type opcode 3'b111.
  assign is_halt = ir_q[8] & (ir_q[7:5] == 3'b111);

  always_comb begin
    state_d = state_q;
    fetch_d = fetch_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          fetch_d = startAddr;
          cnt_d   = '0;
          done_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          // Every executed instruction retires, including branches and HALT.
          if (valid_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
          if (valid_q && is_halt) begin
            // HALT wins over a simultaneous branch; fetch is not redirected.
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_HALT;
          end else if (valid_q && branch) begin
            // The word at imemAddr this cycle is wrong-path: drop it.
            fetch_d = target;
            valid_d = 1'b0;
          end else begin
            ir_d    = imemData;
            pc_d    = fetch_q;
            valid_d = 1'b1;
            fetch_d = fetch_q + PC_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fetch_q <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fetch_q <= fetch_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imemAddr   = fetch_q;
  assign typeCode   = ir_q[8];
  assign rOp        = ir_q[7:4];
  assign regSel     = ir_q[3:0];
  assign iOp        = ir_q[7:5];
  assign imm        = ir_q[4:0];
  assign instrValid = valid_q;
  assign pc         = pc_q;
  assign done       = done_q;
  assign instrCount = cnt_q;

endmodule

// File: doc/fetch_decode.md
Name: fetch_decode

Overview:
Instruction fetch and field-decode stage that sits directly upstream of the ALU in the 8-bit accumulator processor. It owns the program counter and reads 9-bit instructions from an external instruction memory with combinational read. It holds the current instruction in an instruction register and splits it into the ALU control fields: typeCode, rOp, iOp, imm, and register select. It consumes the ALU branch flag and jump target to redirect fetch, and it flushes the one wrong-path instruction after each taken branch.

Parameters:
PC_W, 10, program counter / instruction address width
INSTR_W, 9, instruction width (fixed at 9; other values unsupported)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin execution at startAddr (sampled in IDLE or HALT only)
startAddr  in  PC_W  first instruction address
stall  in  1  freeze stage (downstream memory busy)
branch  in  1  ALU branch flag for the instruction currently in IR
target  in  PC_W  branch/jump destination (from opReg path)
imemAddr  out  PC_W  instruction memory address (= fetchPc)
imemData  in  INSTR_W  instruction memory read data, same cycle
typeCode  out  1  IR[8]
rOp  out  4  IR[7:4]
regSel  out  4  IR[3:0]
iOp  out  3  IR[7:5]
imm  out  5  IR[4:0]
instrValid  out  1  IR holds a valid instruction to execute this cycle
pc  out  PC_W  address of the instruction in IR
done  out  1  HALT retired; held until next start or reset
instrCount  out  CNT_W  retired-instruction count, saturating

Behaviour:
- Reset is synchronous and active-high, on clk. It forces: state=IDLE, fetchPc=0, IR=0, pc=0, instrValid=0, done=0, instrCount=0. Reset asserted mid-run aborts immediately; the next edge gives the reset values.
- Decode fields are combinational slices of IR and are always driven. instrValid qualifies them.
- HALT encoding: typeCode=1, iOp=3'b111 (unused I-type opcode).
- IDLE state: outputs hold their values. When start=1: fetchPc<=startAddr, instrCount<=0, done<=0, go to RUN.
- RUN state, stall=0, per edge:
  - Normal: IR<=imemData, pc<=fetchPc, instrValid<=1, fetchPc<=fetchPc+1.
  - instrValid=1 and branch=1: fetchPc<=target, instrValid<=0 (one-cycle bubble squashes the wrong-path fetch).
  - instrValid=1 and IR is HALT: instrValid<=0, done<=1, go to HALT. HALT takes priority over branch.
  - Every edge with instrValid=1 increments instrCount, including branches and HALT. The count saturates at all-ones.
- Latency: the first instrValid=1 occurs 2 edges after start is sampled.
- RUN state, stall=1: IR, pc, fetchPc, instrValid, and instrCount are all frozen. branch is ignored. imemAddr stays stable.
- fetchPc+1 wraps modulo 2^PC_W with no error.
- HALT state: instrValid=0 and done=1. When start=1, behave as start from IDLE (done cleared, count cleared, go to RUN).
- start is ignored while in RUN.
- branch is ignored whenever instrValid=0.

Test Plan:
- Sequential fetch: reset, then start with startAddr=0 and imem[0..3]={0x02C,0x10D,0x04A,0x1E0}. Required: instrValid first high 2 cycles after start. pc sequence 0,1,2,3. At pc=1: typeCode=1, iOp=000, imm=01101. At pc=3 (0x1E0 = HALT): done=1, instrCount=4.
- Taken branch: instruction at pc=5, branch=1, target=20. Required: next cycle instrValid=0. Cycle after that: pc=20 and IR=imem[20]. Instruction 6 is never valid.
- Stall: assert stall for 3 cycles while pc=7. Required: pc, IR, imemAddr, and instrCount unchanged for those 3 cycles. branch pulses during the stall have no effect. pc=8 follows the first unstalled edge.
- Wrap-around: startAddr=1022 with PC_W=10 and no branches. Required: pc sequence 1022, 1023, 0, 1.
- Simultaneous HALT and branch: HALT in IR with branch=1 and target=50. Required: HALT state, done=1, fetch not redirected.
- Reset mid-run: reset asserted at pc=12. Required: next edge gives state IDLE, pc=0, instrValid=0, done=0, instrCount=0. start with startAddr=3 then resumes with first valid pc=3.
